// File: rtl/cmd_queue_mc.sv
// Multi-channel round-robin command queue feeding a first-word-fall-through FIFO.
// Optional perf counters (io_hwm, io_stall_cnt) under `define CMDQ_PERF_CNT_EN.
module cmd_queue_mc #(
  parameter int CH_NUM     = 2,
  parameter int TYPE_WIDTH = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int BRST_WIDTH = 6,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = 14,
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [CH_NUM-1:0]            io_push_valid,
  output logic [CH_NUM-1:0]            io_push_ready,
  input  logic [CH_NUM*TYPE_WIDTH-1:0] io_push_cmd_type,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] io_push_addr,
  input  logic [CH_NUM*BRST_WIDTH-1:0] io_push_burst_cnt,
  input  logic [CH_NUM*DATA_WIDTH-1:0] io_push_wt_data,
  input  logic [CH_NUM*MASK_WIDTH-1:0] io_push_wt_mask,
  input  logic                         io_pop_valid,
  output logic                         io_pop_ready,
  output logic [CH_W-1:0]              io_pop_ch_id,
  output logic [TYPE_WIDTH-1:0]        io_pop_cmd_type,
  output logic [ADDR_WIDTH-1:0]        io_pop_addr,
  output logic [BRST_WIDTH-1:0]        io_pop_burst_cnt,
  output logic [DATA_WIDTH-1:0]        io_pop_wt_data,
  output logic [MASK_WIDTH-1:0]        io_pop_wt_mask,
  output logic [PTR_W:0]               io_count,
`ifdef CMDQ_PERF_CNT_EN
  output logic [PTR_W:0]               io_hwm,
  output logic [31:0]                  io_stall_cnt,
`endif
  output logic                         io_almost_full
);

  localparam int CMD_W =
    TYPE_WIDTH + ADDR_WIDTH + BRST_WIDTH + DATA_WIDTH + MASK_WIDTH;
  localparam int ENT_W = CH_W + CMD_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr, rd, wr_nxt, rd_nxt;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt;
  logic             gnt_ok;
  logic             full, empty;
  logic             push_fire, pop_fire;

  assign full  = (wr ^ rd) == {1'b1, {PTR_W{1'b0}}};
  assign empty = (wr == rd);

  always_comb begin
    int idx;
    idx    = 0;
    gnt_ok = 1'b0;
    gnt    = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (int'(rr_ptr) + k) % CH_NUM;
      if (!gnt_ok && io_push_valid[idx]) begin
        gnt_ok = 1'b1;
        gnt    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    io_push_ready = '0;
    if (rstn && !full && gnt_ok)
      io_push_ready[gnt] = 1'b1;
  end

  assign push_fire = |(io_push_valid & io_push_ready);
  assign io_pop_ready = rstn && !empty;
  assign pop_fire  = io_pop_valid && io_pop_ready;

  assign wr_nxt = wr + (PTR_W+1)'(push_fire);
  assign rd_nxt = rd + (PTR_W+1)'(pop_fire);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr     <= '0;
      rd     <= '0;
      rr_ptr <= '0;
    end else begin
      wr <= wr_nxt;
      rd <= rd_nxt;
      if (push_fire)
        rr_ptr <= (int'(gnt) == CH_NUM-1) ? '0 : gnt + 1'b1;
    end
  end

  // Storage carries no reset; stale contents are masked by io_pop_ready.
  always_ff @(posedge clk) begin
    if (push_fire)
      mem[wr[PTR_W-1:0]] <= {
        gnt,
        io_push_cmd_type[gnt*TYPE_WIDTH +: TYPE_WIDTH],
        io_push_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH],
        io_push_burst_cnt[gnt*BRST_WIDTH +: BRST_WIDTH],
        io_push_wt_data[gnt*DATA_WIDTH +: DATA_WIDTH],
        io_push_wt_mask[gnt*MASK_WIDTH +: MASK_WIDTH]
      };
  end

  logic [ENT_W-1:0] head;
  assign head = io_pop_ready ? mem[rd[PTR_W-1:0]] : '0;
  assign {io_pop_ch_id, io_pop_cmd_type, io_pop_addr,
          io_pop_burst_cnt, io_pop_wt_data, io_pop_wt_mask} = head;

  assign io_count       = wr - rd;
  assign io_almost_full = io_count >= (PTR_W+1)'(AFULL_TH);

`ifdef CMDQ_PERF_CNT_EN
  logic [PTR_W:0] cnt_nxt;
  assign cnt_nxt = wr_nxt - rd_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io_hwm       <= '0;
      io_stall_cnt <= '0;
    end else begin
      if (cnt_nxt > io_hwm)
        io_hwm <= cnt_nxt;
      if (|io_push_valid && !push_fire && io_stall_cnt != 32'hFFFF_FFFF)
        io_stall_cnt <= io_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_queue_mc.sv
// Directed bench for cmd_queue_mc: latency, arbitration, full/empty, wrap, reset.
// Perf counter checks compile in when CMDQ_PERF_CNT_EN is defined.
module tb_cmd_queue_mc;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    push_valid;
  logic [1:0]    push_ready;
  logic [3:0]    push_type;
  logic [53:0]   push_addr;
  logic [11:0]   push_brst;
  logic [255:0]  push_data;
  logic [31:0]   push_mask;
  logic          pop_valid;
  logic          pop_ready;
  logic [0:0]    pop_ch_id;
  logic [1:0]    pop_type;
  logic [26:0]   pop_addr;
  logic [5:0]    pop_brst;
  logic [127:0]  pop_data;
  logic [15:0]   pop_mask;
  logic [4:0]    count;
  logic          almost_full;
`ifdef CMDQ_PERF_CNT_EN
  logic [4:0]    hwm;
  logic [31:0]   stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  cmd_queue_mc dut (
    .clk               (clk),
    .rstn              (rstn),
    .io_push_valid     (push_valid),
    .io_push_ready     (push_ready),
    .io_push_cmd_type  (push_type),
    .io_push_addr      (push_addr),
    .io_push_burst_cnt (push_brst),
    .io_push_wt_data   (push_data),
    .io_push_wt_mask   (push_mask),
    .io_pop_valid      (pop_valid),
    .io_pop_ready      (pop_ready),
    .io_pop_ch_id      (pop_ch_id),
    .io_pop_cmd_type   (pop_type),
    .io_pop_addr       (pop_addr),
    .io_pop_burst_cnt  (pop_brst),
    .io_pop_wt_data    (pop_data),
    .io_pop_wt_mask    (pop_mask),
    .io_count          (count),
`ifdef CMDQ_PERF_CNT_EN
    .io_hwm            (hwm),
    .io_stall_cnt      (stall_cnt),
`endif
    .io_almost_full    (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] t,
                        input logic [26:0] a, input logic [5:0] b,
                        input logic [127:0] d, input logic [15:0] m);
    push_type[ch*2 +: 2]     = t;
    push_addr[ch*27 +: 27]   = a;
    push_brst[ch*6 +: 6]     = b;
    push_data[ch*128 +: 128] = d;
    push_mask[ch*16 +: 16]   = m;
  endtask

  initial begin
    rstn       = 1'b0;
    push_valid = '0;
    pop_valid  = 1'b0;
    push_type  = '0;
    push_addr  = '0;
    push_brst  = '0;
    push_data  = '0;
    push_mask  = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_pop_rdy", pop_ready, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_pop_addr", pop_addr, 0);
    push_valid = 2'b11;
    #1;
    chk("rst_push_rdy", push_ready, 2'b00);
    push_valid = '0;
    rstn = 1'b1;
    #1;

    // single push: visible one cycle later
    set_ch(0, 2'd1, 27'h100, 6'd4, {4{32'hDEAD_BEEF}}, 16'hA5A5);
    push_valid = 2'b01;
    #1;
    chk("t1_push_rdy", push_ready, 2'b01);
    chk("t1_no_bypass", pop_ready, 0);
    step();
    push_valid = '0;
    #1;
    chk("t1_pop_rdy", pop_ready, 1);
    chk("t1_ch_id", pop_ch_id, 0);
    chk("t1_type", pop_type, 1);
    chk("t1_addr", pop_addr, 27'h100);
    chk("t1_brst", pop_brst, 4);
    chk("t1_data", pop_data, {4{32'hDEAD_BEEF}});
    chk("t1_mask", pop_mask, 16'hA5A5);
    chk("t1_count", count, 1);
    pop_valid = 1'b1;
    step();
    pop_valid = 1'b0;
    #1;
    chk("t1_count_empty", count, 0);
    chk("t1_pop_rdy_empty", pop_ready, 0);
    chk("t1_addr_zero", pop_addr, 0);

    // both valid: ch0 was last served, so rr starts at ch1
    set_ch(0, 2'd2, 27'hA00, 6'd1, 128'h1, 16'h1);
    set_ch(1, 2'd3, 27'hB00, 6'd2, 128'h2, 16'h2);
    push_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_grant", push_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    push_valid = '0;
    #1;
    chk("t2_count", count, 8);
    pop_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_order_ch", pop_ch_id, (k % 2 == 0) ? 1 : 0);
      chk("t2_order_addr", pop_addr, (k % 2 == 0) ? 27'hB00 : 27'hA00);
      step();
    end
    pop_valid = 1'b0;
    #1;
    chk("t2_drained", count, 0);

    // fill to full, almost_full threshold
    push_valid = 2'b01;
    for (int k = 0; k < 16; k++) begin
      set_ch(0, 2'd0, 27'(k), 6'd0, 128'(k), 16'h0);
      #1;
      chk("t3_count", count, k);
      chk("t3_afull", almost_full, (k >= 14) ? 1 : 0);
      chk("t3_push_rdy", push_ready, 2'b01);
      step();
    end
    #1;
    chk("t3_full_count", count, 16);
    chk("t3_full_afull", almost_full, 1);
    chk("t3_full_rdy", push_ready, 2'b00);
    set_ch(0, 2'd0, 27'h77, 6'd0, 128'h77, 16'h0);
    pop_valid = 1'b1;
    #1;
    chk("t3_full_pop_rdy", push_ready, 2'b00);
    step();
    push_valid = '0;
    #1;
    chk("t3_pop_only", count, 15);
    chk("t3_head", pop_addr, 1);
    for (int k = 1; k < 16; k++) begin
      #1;
      chk("t3_drain", pop_addr, k);
      step();
    end
    pop_valid = 1'b0;
    #1;
    chk("t3_empty", count, 0);

    // empty: push fires, pop does not
    set_ch(0, 2'd0, 27'h55, 6'd0, 128'h55, 16'h0);
    push_valid = 2'b01;
    pop_valid  = 1'b1;
    #1;
    chk("t3e_pop_rdy", pop_ready, 0);
    step();
    push_valid = '0;
    #1;
    chk("t3e_count", count, 1);
    chk("t3e_addr", pop_addr, 27'h55);
    step();
    pop_valid = 1'b0;
    #1;
    chk("t3e_count0", count, 0);

    // steady push+pop at count 3 across pointer wrap
    push_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      set_ch(1, 2'd0, 27'(12'h300 + i), 6'd0, 128'h0, 16'h0);
      step();
    end
    #1;
    chk("t4_count3", count, 3);
    pop_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_ch(1, 2'd0, 27'(12'h303 + i), 6'd0, 128'h0, 16'h0);
      #1;
      chk("t4_head", pop_addr, 27'(12'h300 + i));
      chk("t4_count", count, 3);
      step();
    end
    push_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_tail", pop_addr, 27'(12'h300 + 40 + i));
      step();
    end
    pop_valid = 1'b0;
    #1;
    chk("t4_empty", count, 0);

    // async reset mid-operation with count 9; rr_ptr=1 beforehand
    push_valid = 2'b01;
    for (int i = 0; i < 9; i++) begin
      set_ch(0, 2'd3, 27'(12'h400 + i), 6'd0, 128'h0, 16'h0);
      step();
    end
    push_valid = '0;
    #1;
    chk("t5_count9", count, 9);
    rstn = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_pop_rdy", pop_ready, 0);
    chk("t5_addr", pop_addr, 0);
    chk("t5_type", pop_type, 0);
    chk("t5_ch", pop_ch_id, 0);
    push_valid = 2'b11;
    #1;
    chk("t5_push_rdy_rst", push_ready, 2'b00);
    rstn = 1'b1;
    #1;
    chk("t5_rr_ch0", push_ready, 2'b01);
    step();
    chk("t5_rr_ch1", push_ready, 2'b10);
    push_valid = '0;

`ifdef CMDQ_PERF_CNT_EN
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    #1;
    chk("t6_stall0", stall_cnt, 0);
    chk("t6_hwm0", hwm, 0);
    push_valid = 2'b11;
    repeat (16) step();
    chk("t6_full", count, 16);
    chk("t6_hwm_full", hwm, 16);
    chk("t6_no_stall", stall_cnt, 0);
    repeat (5) step();
    chk("t6_stall5", stall_cnt, 5);
    chk("t6_hwm16", hwm, 16);
    push_valid = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
